// File: rtl/eth_phy_mgmt_seq.sv
// eth_phy_mgmt_seq: MDIO management sequencer for the RMII PHY.
// Brings the PHY out of soft reset, writes the operating mode, then polls
// BMSR/SCSR for link, speed and duplex status. Host register accesses are
// slotted in between sequencer operations. Every MDIO operation is an
// ISSUE cycle followed by a WAIT phase bounded by a timeout counter.
module eth_phy_mgmt_seq #(
    parameter logic [4:0]  PHY_ADDR    = 5'h01,
    parameter int          RST_WAIT    = 50000,
    parameter int          POLL_PERIOD = 100000,
    parameter int          TIMEOUT     = 4096,
    parameter logic [15:0] BMCR_CFG    = 16'h3100
) (
    input  logic        clk_100_mhz,
    input  logic        rst,
    output logic        DM_start,
    output logic        DM_mode,
    output logic [4:0]  DM_addr,
    output logic [4:0]  DM_reg_addr,
    output logic [15:0] DM_data_i,
    input  logic [15:0] DM_data_o,
    input  logic        DM_done,
    input  logic        host_req,
    input  logic        host_mode,
    input  logic [4:0]  host_reg_addr,
    input  logic [15:0] host_wdata,
    output logic        host_ack,
    output logic [15:0] host_rdata,
    output logic        init_done,
    output logic        link_up,
    output logic        speed_100,
    output logic        full_duplex,
    output logic        timeout_err
);

    localparam logic [2:0] S_RST_WR    = 3'd0;
    localparam logic [2:0] S_RST_WAIT  = 3'd1;
    localparam logic [2:0] S_RST_CHK   = 3'd2;
    localparam logic [2:0] S_CFG_WR    = 3'd3;
    localparam logic [2:0] S_IDLE      = 3'd4;
    localparam logic [2:0] S_POLL_BMSR = 3'd5;
    localparam logic [2:0] S_POLL_SCSR = 3'd6;
    localparam logic [2:0] S_HOST      = 3'd7;

    localparam logic [15:0] RST_LAST   = 16'(RST_WAIT - 1);
    localparam logic [16:0] POLL_LAST  = 17'(POLL_PERIOD - 1);
    localparam logic [15:0] TMO_LIMIT  = 16'(TIMEOUT);
    localparam logic [15:0] BMCR_RESET = 16'h8000;
    localparam logic [4:0]  REG_BMCR   = 5'd0;
    localparam logic [4:0]  REG_BMSR   = 5'd1;
    localparam logic [4:0]  REG_SCSR   = 5'd31;

    logic [2:0]  state;
    logic        waiting;
    logic [15:0] tmo_cnt;
    logic [15:0] wait_cnt;
    logic [16:0] poll_cnt;
    logic        hst_mode;
    logic [4:0]  hst_reg;
    logic [15:0] hst_wdata;

    logic        is_op;
    logic        op_mode;
    logic [4:0]  op_reg;
    logic [15:0] op_data;
    logic        op_done;
    logic        op_tmo;
    logic        host_take;
    logic        poll_due;

    // Decode which MDIO operation (if any) the current state performs.
    always_comb begin
        is_op   = 1'b1;
        op_mode = 1'b1;
        op_reg  = REG_BMCR;
        op_data = 16'h0000;
        case (state)
            S_RST_WR: begin
                op_mode = 1'b0;
                op_data = BMCR_RESET;
            end
            S_RST_CHK: begin
                op_reg = REG_BMCR;
            end
            S_CFG_WR: begin
                op_mode = 1'b0;
                op_data = BMCR_CFG;
            end
            S_POLL_BMSR: begin
                op_reg = REG_BMSR;
            end
            S_POLL_SCSR: begin
                op_reg = REG_SCSR;
            end
            S_HOST: begin
                op_mode = hst_mode;
                op_reg  = hst_reg;
                op_data = hst_wdata;
            end
            S_RST_WAIT, S_IDLE: begin
                is_op = 1'b0;
            end
            default: begin
                is_op = 1'b0;
            end
        endcase
    end

    // Completion, timeout and arbitration qualifiers; a done pulse outside WAIT is ignored.
    always_comb begin
        op_done   = is_op & waiting & DM_done;
        op_tmo    = is_op & waiting & ~DM_done & (tmo_cnt == TMO_LIMIT);
        // The ack cycle still sees the old request, so it must not re-enter S_HOST.
        host_take = (state == S_IDLE) & init_done & host_req & ~host_ack;
        poll_due  = (poll_cnt == POLL_LAST);
    end

    // MDIO handshake: issue pulse, stable request fields, timeout counter, sticky error.
    always_ff @(posedge clk_100_mhz or posedge rst) begin
        if (rst) begin
            DM_start    <= 1'b0;
            DM_mode     <= 1'b0;
            DM_addr     <= PHY_ADDR;
            DM_reg_addr <= 5'd0;
            DM_data_i   <= 16'h0000;
            waiting     <= 1'b0;
            tmo_cnt     <= 16'd0;
            timeout_err <= 1'b0;
        end else begin
            DM_addr  <= PHY_ADDR;
            DM_start <= 1'b0;
            if (is_op && !waiting) begin
                DM_start    <= 1'b1;
                DM_mode     <= op_mode;
                DM_reg_addr <= op_reg;
                DM_data_i   <= op_data;
                waiting     <= 1'b1;
                tmo_cnt     <= 16'd0;
            end else if (op_done) begin
                waiting <= 1'b0;
            end else if (op_tmo) begin
                waiting     <= 1'b0;
                timeout_err <= 1'b1;
            end else if (waiting) begin
                tmo_cnt <= tmo_cnt + 16'd1;
            end
        end
    end

    // Sequencer state, wait/poll counters, host capture and status outputs.
    always_ff @(posedge clk_100_mhz or posedge rst) begin
        if (rst) begin
            state       <= S_RST_WR;
            wait_cnt    <= 16'd0;
            poll_cnt    <= 17'd0;
            hst_mode    <= 1'b0;
            hst_reg     <= 5'd0;
            hst_wdata   <= 16'h0000;
            host_ack    <= 1'b0;
            host_rdata  <= 16'h0000;
            init_done   <= 1'b0;
            link_up     <= 1'b0;
            speed_100   <= 1'b0;
            full_duplex <= 1'b0;
        end else begin
            host_ack <= 1'b0;
            case (state)
                S_RST_WR: begin
                    if (op_done) begin
                        state    <= S_RST_WAIT;
                        wait_cnt <= 16'd0;
                    end
                end
                S_RST_WAIT: begin
                    if (wait_cnt == RST_LAST) begin
                        state <= S_RST_CHK;
                    end else begin
                        wait_cnt <= wait_cnt + 16'd1;
                    end
                end
                S_RST_CHK: begin
                    if (op_done) begin
                        if (DM_data_o[15]) begin
                            state    <= S_RST_WAIT;
                            wait_cnt <= 16'd0;
                        end else begin
                            state <= S_CFG_WR;
                        end
                    end else if (op_tmo) begin
                        state <= S_RST_WR;
                    end
                end
                S_CFG_WR: begin
                    if (op_done) begin
                        init_done <= 1'b1;
                        state     <= S_IDLE;
                    end else if (op_tmo) begin
                        state <= S_RST_WR;
                    end
                end
                S_IDLE: begin
                    // Saturate at expiry so a poll deferred by the host is not lost.
                    if (!poll_due) begin
                        poll_cnt <= poll_cnt + 17'd1;
                    end
                    if (host_take) begin
                        state     <= S_HOST;
                        hst_mode  <= host_mode;
                        hst_reg   <= host_reg_addr;
                        hst_wdata <= host_wdata;
                    end else if (poll_due) begin
                        poll_cnt <= 17'd0;
                        state    <= S_POLL_BMSR;
                    end
                end
                S_POLL_BMSR: begin
                    if (op_done) begin
                        link_up <= DM_data_o[2];
                        if (DM_data_o[2]) begin
                            state <= S_POLL_SCSR;
                        end else begin
                            speed_100   <= 1'b0;
                            full_duplex <= 1'b0;
                            state       <= S_IDLE;
                        end
                    end else if (op_tmo) begin
                        link_up <= 1'b0;
                        state   <= S_IDLE;
                    end
                end
                S_POLL_SCSR: begin
                    if (op_done) begin
                        speed_100   <= DM_data_o[3];
                        full_duplex <= DM_data_o[4];
                        state       <= S_IDLE;
                    end else if (op_tmo) begin
                        state <= S_IDLE;
                    end
                end
                S_HOST: begin
                    if (op_done) begin
                        host_ack <= 1'b1;
                        if (hst_mode) begin
                            host_rdata <= DM_data_o;
                        end
                        state <= S_IDLE;
                    end else if (op_tmo) begin
                        host_ack   <= 1'b1;
                        host_rdata <= 16'hFFFF;
                        state      <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_RST_WR;
                end
            endcase
        end
    end

endmodule
